// File: rtl/axis_packetizer_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// axis_packetizer_if : AXI4-Stream bundle for the packetizer input/output sides
// Revision: 1.0
// -----------------------------------------------------------------------------
interface axis_packetizer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  // The input side carries no packet boundaries, so tlast is absent from slave.
  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_packetizer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// axis_packetizer : cuts a continuous AXI4-Stream into fixed-length tlast packets
// Revision: 1.0
// -----------------------------------------------------------------------------
module axis_packetizer #(
  parameter int    AXIS_TDATA_WIDTH = 32,
  parameter int    CNTR_WIDTH       = 16,
  parameter string CONTINUOUS       = "TRUE"
) (
  input  wire logic                  aclk,
  input  wire logic                  areset,
  input  wire logic [CNTR_WIDTH-1:0] cfg_data,
  input  wire logic                  cfg_enable,
  axis_packetizer_if.slave           s_axis,
  axis_packetizer_if.master          m_axis,
  output logic [CNTR_WIDTH-1:0]      sts_data,
  output logic                       sts_busy
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;
  localparam bit         c_continuous = (CONTINUOUS == "TRUE");

  logic [1:0]                  r_state;
  logic [1:0]                  w_state_next;
  logic [CNTR_WIDTH-1:0]       r_len;
  logic [CNTR_WIDTH-1:0]       r_cnt;
  logic [AXIS_TDATA_WIDTH-1:0] r_m_data;
  logic                        r_m_valid;
  logic                        r_m_last;
  logic [CNTR_WIDTH-1:0]       r_sts;
  logic                        w_run;
  logic                        w_s_ready;
  logic                        w_in_xfer;
  logic                        w_out_xfer;
  logic                        w_is_last;
  logic                        w_reload;

  assign w_in_xfer  = s_axis.tvalid & w_s_ready;
  assign w_out_xfer = r_m_valid & m_axis.tready;
  assign w_is_last  = (r_cnt == r_len);
  assign w_reload   = c_continuous & cfg_enable;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // RUN is left only on a last-word transfer, so packets are never truncated.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (cfg_enable) w_state_next = c_st_run;
      c_st_run:  if (w_in_xfer && w_is_last && !w_reload) w_state_next = c_st_done;
      c_st_done: if (!cfg_enable) w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_run     = (r_state == c_st_run);
    w_s_ready = w_run & (~r_m_valid | m_axis.tready);
    sts_busy  = w_run;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if ((r_state == c_st_idle) && cfg_enable) begin
      r_len <= cfg_data;
      r_cnt <= '0;
    end else if (w_in_xfer) begin
      if (w_is_last) begin
        r_cnt <= '0;
        if (w_reload) r_len <= cfg_data;
      end else begin
        r_cnt <= r_cnt + CNTR_WIDTH'(1);
      end
    end
  end

  // Output register drains independently of state so a held word still leaves.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (w_in_xfer) begin
      r_m_data  <= s_axis.tdata;
      r_m_valid <= 1'b1;
      r_m_last  <= w_is_last;
    end else if (m_axis.tready) begin
      r_m_valid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_sts <= '0;
    end else if (w_out_xfer && r_m_last) begin
      r_sts <= r_sts + CNTR_WIDTH'(1);
    end
  end

  assign s_axis.tready = w_s_ready;
  assign m_axis.tdata  = r_m_data;
  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tlast  = r_m_last;
  assign sts_data      = r_sts;

endmodule
`default_nettype wire
